mac_accumulator: RTL and testbench

Accumulation stage directly downstream of the MAC unit's adder array. It consumes signed products over a valid/ready handshake and sums them into a saturating signed accumulator. It closes a frame on an explicit LAST_I beat or after FRAME_N beats, then presents the frame result on a held valid/ready output. This is the sequential back end that turns the combinational adder tree into a usable multiply-accumulate.

---
 rtl/mac_accumulator.sv | 133 +++++++++++++
 tb/tb_mac_accumulator.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accumulator.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | mac_accumulator: saturating signed frame accumulator behind the MAC     |
// | adder array, valid/ready in and held valid/ready result out.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mac_accumulator #(
  parameter int P_W     = 16,
  parameter int ACC_W   = 24,
  parameter int FRAME_N = 8
) (
  input  logic                    CLK_I,
  input  logic                    RST_I,
  input  logic                    CLR_I,
  input  logic signed [P_W-1:0]   PROD_I,
  input  logic                    PROD_VALID_I,
  input  logic                    LAST_I,
  output logic                    PROD_READY_O,
  output logic signed [ACC_W-1:0] ACC_O,
  output logic                    ACC_VALID_O,
  input  logic                    ACC_READY_I,
  output logic                    OVF_O
);

  localparam int                  c_CNT_W   = $clog2(FRAME_N + 1);
  localparam logic [c_CNT_W-1:0]  c_FRAME_N = c_CNT_W'(FRAME_N);
  localparam logic [0:0]          c_ST_ACCUM = 1'b0;
  localparam logic [0:0]          c_ST_HOLD  = 1'b1;

  logic [0:0]               state_q, state_d;
  logic                     ready_q, ready_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [c_CNT_W-1:0]       cnt_q, cnt_d;
  logic                     ovf_q, ovf_d;
  logic signed [ACC_W-1:0]  res_q, res_d;
  logic                     res_ovf_q, res_ovf_d;
  logic                     res_vld_q, res_vld_d;

  logic                     w_accept;
  logic signed [ACC_W:0]    w_sum;
  logic                     w_pos_ovf;
  logic                     w_neg_ovf;
  logic                     w_sat_hit;
  logic signed [ACC_W-1:0]  w_sat;
  logic [c_CNT_W-1:0]       w_cnt_inc;
  logic                     w_close;

  // ready_q stays low for the first cycle after reset release, then tracks ACCUM
  assign PROD_READY_O = ready_q & ~CLR_I;
  assign w_accept     = PROD_VALID_I & PROD_READY_O;

  assign w_sum     = {acc_q[ACC_W-1], acc_q}
                   + {{(ACC_W + 1 - P_W){PROD_I[P_W-1]}}, PROD_I};
  assign w_pos_ovf = ~w_sum[ACC_W] &  w_sum[ACC_W-1];
  assign w_neg_ovf =  w_sum[ACC_W] & ~w_sum[ACC_W-1];
  assign w_sat_hit = w_pos_ovf | w_neg_ovf;
  assign w_sat     = w_pos_ovf ? {1'b0, {(ACC_W-1){1'b1}}} :
                     w_neg_ovf ? {1'b1, {(ACC_W-1){1'b0}}} :
                                 w_sum[ACC_W-1:0];

  assign w_cnt_inc = cnt_q + 1'b1;
  assign w_close   = LAST_I | (w_cnt_inc == c_FRAME_N);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    res_d     = res_q;
    res_ovf_d = res_ovf_q;
    res_vld_d = res_vld_q;
    if (CLR_I) begin
      state_d   = c_ST_ACCUM;
      acc_d     = '0;
      cnt_d     = '0;
      ovf_d     = 1'b0;
      res_d     = '0;
      res_ovf_d = 1'b0;
      res_vld_d = 1'b0;
    end else if (state_q == c_ST_ACCUM) begin
      if (w_accept) begin
        if (w_close) begin
          res_d     = w_sat;
          res_ovf_d = ovf_q | w_sat_hit;
          res_vld_d = 1'b1;
          state_d   = c_ST_HOLD;
          acc_d     = '0;
          cnt_d     = '0;
          ovf_d     = 1'b0;
        end else begin
          acc_d = w_sat;
          cnt_d = w_cnt_inc;
          ovf_d = ovf_q | w_sat_hit;
        end
      end
    end else begin
      if (ACC_READY_I) begin
        res_vld_d = 1'b0;
        state_d   = c_ST_ACCUM;
      end
    end
    ready_d = (state_d == c_ST_ACCUM);
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q   <= c_ST_ACCUM;
      ready_q   <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      res_q     <= '0;
      res_ovf_q <= 1'b0;
      res_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      res_q     <= res_d;
      res_ovf_q <= res_ovf_d;
      res_vld_q <= res_vld_d;
    end
  end

  assign ACC_O       = res_q;
  assign OVF_O       = res_ovf_q;
  assign ACC_VALID_O = res_vld_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_accumulator.sv
`timescale 1ns/1ps
`default_nettype none
// Randomised scoreboard bench for mac_accumulator (ACC_W=17 to reach saturation).
module tb_mac_accumulator;

  localparam int     P_W     = 16;
  localparam int     ACC_W   = 17;
  localparam int     FRAME_N = 8;
  localparam longint ACC_MAX = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) <<< (ACC_W - 1));

  logic             CLK_I        = 1'b0;
  logic             RST_I        = 1'b1;
  logic             CLR_I        = 1'b0;
  logic [P_W-1:0]   PROD_I       = '0;
  logic             PROD_VALID_I = 1'b0;
  logic             LAST_I       = 1'b0;
  logic             ACC_READY_I  = 1'b0;
  logic             PROD_READY_O;
  logic [ACC_W-1:0] ACC_O;
  logic             ACC_VALID_O;
  logic             OVF_O;

  mac_accumulator #(.P_W(P_W), .ACC_W(ACC_W), .FRAME_N(FRAME_N)) dut (
    .CLK_I        (CLK_I),
    .RST_I        (RST_I),
    .CLR_I        (CLR_I),
    .PROD_I       (PROD_I),
    .PROD_VALID_I (PROD_VALID_I),
    .LAST_I       (LAST_I),
    .PROD_READY_O (PROD_READY_O),
    .ACC_O        (ACC_O),
    .ACC_VALID_O  (ACC_VALID_O),
    .ACC_READY_I  (ACC_READY_I),
    .OVF_O        (OVF_O)
  );

  always #5 CLK_I = ~CLK_I;

  typedef struct {
    longint acc;
    bit     ovf;
  } res_t;

  res_t   exp_q[$];
  int     n_checks = 0;
  int     n_pass   = 0;

  // Frame-level reference: running sum clamped per beat, sticky overflow
  longint m_acc   = 0;
  int     m_cnt   = 0;
  bit     m_ovf   = 1'b0;
  bit     m_hold  = 1'b0;
  bit     m_fresh = 1'b1;

  function automatic void check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endfunction

  function automatic void model_step(input bit v, input bit last, input bit ar, input bit clr);
    longint pv;
    res_t   r;
    pv = longint'($signed(PROD_I));
    if (clr) begin
      m_hold = 1'b0; m_acc = 0; m_cnt = 0; m_ovf = 1'b0;
    end else if (m_fresh) begin
      // no beat is taken before the first edge after reset release
    end else if (m_hold) begin
      if (ar) m_hold = 1'b0;
    end else if (v) begin
      m_acc = m_acc + pv;
      if (m_acc > ACC_MAX) begin m_acc = ACC_MAX; m_ovf = 1'b1; end
      else if (m_acc < ACC_MIN) begin m_acc = ACC_MIN; m_ovf = 1'b1; end
      m_cnt++;
      if (last || m_cnt == FRAME_N) begin
        r.acc = m_acc;
        r.ovf = m_ovf;
        exp_q.push_back(r);
        m_hold = 1'b1; m_acc = 0; m_cnt = 0; m_ovf = 1'b0;
      end
    end
    m_fresh = 1'b0;
  endfunction

  task automatic cycle(input bit v, input longint p, input bit last, input bit ar, input bit clr);
    PROD_VALID_I = v;
    PROD_I       = P_W'(p);
    LAST_I       = last;
    ACC_READY_I  = ar;
    CLR_I        = clr;
    @(negedge CLK_I);
    check("prod_ready", longint'(PROD_READY_O), longint'(!m_fresh && !m_hold && !clr));
    check("acc_valid", longint'(ACC_VALID_O), longint'(m_hold));
    model_step(v, last, ar, clr);
    @(posedge CLK_I);
    #1;
  endtask

  task automatic apply_reset();
    RST_I = 1'b1; CLR_I = 1'b0; PROD_VALID_I = 1'b0; LAST_I = 1'b0; ACC_READY_I = 1'b0;
    m_acc = 0; m_cnt = 0; m_ovf = 1'b0; m_hold = 1'b0; m_fresh = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge CLK_I);
    #1;
    RST_I = 1'b0;
  endtask

  // Monitor: pops one expected result per rising ACC_VALID_O, then checks it is held
  logic             prev_valid   = 1'b0;
  logic             prev_handoff = 1'b0;
  logic [ACC_W-1:0] held_acc     = '0;
  logic             held_ovf     = 1'b0;

  always @(negedge CLK_I) begin : monitor
    res_t e;
    if (RST_I) begin
      prev_valid <= 1'b0;
    end else begin
      if (ACC_VALID_O && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("acc_o", longint'($signed(ACC_O)), e.acc);
          check("ovf_o", longint'(OVF_O), longint'(e.ovf));
        end
        held_acc <= ACC_O;
        held_ovf <= OVF_O;
      end else if (ACC_VALID_O && prev_valid && !prev_handoff) begin
        check("hold_acc_stable", longint'($signed(ACC_O)), longint'($signed(held_acc)));
        check("hold_ovf_stable", longint'(OVF_O), longint'(held_ovf));
      end
      prev_valid   <= ACC_VALID_O;
      prev_handoff <= ACC_READY_I | CLR_I;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    longint p;
    #3;
    check("reset_acc_o", longint'(ACC_O), 0);
    check("reset_valid", longint'(ACC_VALID_O), 0);
    check("reset_ovf", longint'(OVF_O), 0);
    check("reset_ready", longint'(PROD_READY_O), 0);
    apply_reset();
    cycle(1, 123, 0, 0, 0);               // ready still low: not accepted

    // LAST_I frame with immediate hand-off
    cycle(1, 100, 0, 1, 0);
    cycle(1, -30, 0, 1, 0);
    cycle(1, 7, 1, 1, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);

    // FRAME_N close, backpressure, a held 9th beat not consumed during HOLD
    for (int i = 0; i < FRAME_N; i++) cycle(1, 1000, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 9999, 1, 0, 0);
    cycle(1, 9999, 1, 1, 0);
    cycle(1, 9999, 1, 0, 0);
    cycle(0, 0, 0, 1, 0);

    // Positive saturation, then a clean frame
    for (int i = 0; i < FRAME_N; i++) cycle(1, 32767, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(1, 1, 0, 1, 0);
    cycle(1, -1, 1, 1, 0);
    cycle(0, 0, 0, 1, 0);

    // Negative: exact fit, one past, and a full frame
    cycle(1, -32768, 0, 1, 0);
    cycle(1, -32768, 1, 1, 0);
    cycle(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cycle(1, -32768, (i == 2), 1, 0);
    cycle(0, 0, 0, 1, 0);
    for (int i = 0; i < FRAME_N; i++) cycle(1, -32768, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);

    // LAST_I together with count reaching FRAME_N
    for (int i = 0; i < FRAME_N; i++) cycle(1, i + 1, (i == FRAME_N - 1), 1, 0);
    cycle(0, 0, 0, 1, 0);

    // CLR_I mid-frame discards the beat presented with it
    cycle(1, 5, 0, 1, 0);
    cycle(1, 5, 0, 1, 0);
    cycle(1, 5, 0, 1, 1);
    cycle(1, 2, 0, 1, 0);
    cycle(1, 3, 1, 1, 0);
    cycle(0, 0, 0, 1, 0);

    // CLR_I with a closing beat: no result
    cycle(1, 4, 0, 1, 0);
    cycle(1, 6, 1, 1, 1);
    cycle(1, 9, 1, 0, 0);
    cycle(0, 0, 0, 1, 0);

    // CLR_I with ACC_READY_I in HOLD: result discarded and outputs zeroed
    cycle(1, 11, 1, 0, 0);
    cycle(0, 0, 0, 1, 1);
    check("clr_zero_acc", longint'(ACC_O), 0);
    check("clr_zero_ovf", longint'(OVF_O), 0);
    cycle(0, 0, 0, 0, 0);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) < 3) p = ($urandom_range(0, 1) == 1) ? 32767 : -32768;
      else p = longint'($signed(P_W'($urandom)));
      cycle($urandom_range(0, 3) != 0, p, $urandom_range(0, 5) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 49) == 0);
    end
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    check("scoreboard_drain", longint'(exp_q.size()), 0);

    // Asynchronous reset in the middle of HOLD
    cycle(1, 42, 1, 0, 0);
    check("pre_reset_valid", longint'(ACC_VALID_O), 1);
    #2;
    RST_I = 1'b1;
    #1;
    check("async_rst_valid", longint'(ACC_VALID_O), 0);
    check("async_rst_acc", longint'(ACC_O), 0);
    check("async_rst_ovf", longint'(OVF_O), 0);
    check("async_rst_ready", longint'(PROD_READY_O), 0);
    apply_reset();
    cycle(1, 50, 0, 1, 0);
    cycle(1, 50, 1, 1, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    check("final_drain", longint'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
